// File: rtl/pipe_hazard_seq.sv
// Pipeline sequencer for the 5-stage RV32 core: PC/pipe-register enables and flushes,
// covering memory wait, redirect, load-use stalls and Halt drain, plus saturating event counters.
module pipe_hazard_seq #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_pcsel,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_ctr_q, drain_ctr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;
  logic             load_use;

  // A load in EX whose destination feeds the instruction in ID; x0 never hazards.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // State register and saturating counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      drain_ctr_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_ctr_q <= drain_ctr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state, drain countdown and counter-increment decisions
  always_comb begin
    state_d     = state_q;
    drain_ctr_d = drain_ctr_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    unique case (state_q)
      RUN, WAIT_MEM: begin
        if (dmem_busy) begin
          state_d = WAIT_MEM;
        end else if (ex_pcsel) begin
          state_d   = RUN;
          flush_inc = 1'b1;
        end else if (load_use) begin
          state_d   = RUN;
          stall_inc = 1'b1;
        end else if (id_halt) begin
          state_d     = DRAIN;
          drain_ctr_d = DW'(DRAIN_CYCLES);
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!dmem_busy) begin
          drain_ctr_d = drain_ctr_q - DW'(1);
          if (drain_ctr_q <= DW'(1)) state_d = HALTED;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Mealy strobe generation; reset forces bubbles everywhere
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN, WAIT_MEM: begin
          if (dmem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
          end else if (ex_pcsel) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (id_halt) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
          end
        end
        DRAIN: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          if (dmem_busy) begin
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
          end else begin
            idex_flush = 1'b1;
          end
        end
        default: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          halted   = 1'b1;
        end
      endcase
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Directed bench for pipe_hazard_seq: cycle table plus hand-written drain and saturation sequences.
module tb_pipe_hazard_seq;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_halt, ex_memread, ex_pcsel, dmem_busy;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_memwb_en, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_seq #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_halt(id_halt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_pcsel(ex_pcsel), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_seq #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_halt(id_halt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_pcsel(ex_pcsel), .dmem_busy(dmem_busy),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sig = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       halt;
    logic       mr;
    logic [4:0] rd;
    logic       pcsel;
    logic       busy;
    logic [7:0] exp_sig;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } vec_t;

  localparam logic [7:0] S_RST   = 8'b00000_11_0;
  localparam logic [7:0] S_ADV   = 8'b11111_00_0;
  localparam logic [7:0] S_LU    = 8'b00111_01_0;
  localparam logic [7:0] S_REDIR = 8'b11111_11_0;
  localparam logic [7:0] S_FRZ   = 8'b00000_00_0;
  localparam logic [7:0] S_HALTI = 8'b00111_00_0;
  localparam logic [7:0] S_DRAIN = 8'b00111_01_0;
  localparam logic [7:0] S_HALTD = 8'b00000_00_1;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic halt, input logic mr, input logic [4:0] rd,
                              input logic pcsel, input logic busy, input logic [7:0] sig,
                              input int st, input int fl);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.halt = halt; v.mr = mr; v.rd = rd;
    v.pcsel = pcsel; v.busy = busy; v.exp_sig = sig;
    v.exp_stall = 16'(st); v.exp_flush = 16'(fl);
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_halt = v.halt;
    ex_memread = v.mr; ex_rd = v.rd; ex_pcsel = v.pcsel; dmem_busy = v.busy;
  endtask

  function automatic logic [7:0] sig_now();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
  endfunction

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    check({tag, ".strobes"}, {8'd0, sig_now()}, {8'd0, v.exp_sig});
    check({tag, ".stall_cnt"}, stall_cnt, v.exp_stall);
    check({tag, ".flush_cnt"}, flush_cnt, v.exp_flush);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  drain_cycles;
    bit  done;
    vec_t v;

    //        rst rs1 rs2 hlt mr rd pcs bsy sig      st fl
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_RST,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_RST,   0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   0, 0));
    vecs.push_back(mk(1, 0, 5, 0, 1, 5, 0, 0, S_LU,    0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, S_ADV,   1, 0));
    vecs.push_back(mk(1, 7, 7, 0, 1, 7, 0, 0, S_LU,    1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   2, 0));
    vecs.push_back(mk(1, 3, 0, 1, 1, 3, 1, 0, S_REDIR, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, S_FRZ,   2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, S_FRZ,   2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, S_FRZ,   2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, S_REDIR, 2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   2, 2));
    vecs.push_back(mk(1, 9, 0, 0, 1, 9, 0, 1, S_FRZ,   2, 2));
    vecs.push_back(mk(1, 9, 0, 0, 1, 9, 0, 0, S_LU,    2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   3, 2));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, S_HALTI, 3, 2));

    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_rd = '0; ex_pcsel = 1'b0; dmem_busy = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Drain with one busy cycle; redirect and halt requests must be ignored.
    drain_cycles = 0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      v = mk(1, 0, 0, 1, 0, 0, 1, (k == 1), S_DRAIN, 3, 2);
      drive(v);
      @(negedge clk);
      if (halted === 1'b1) begin
        done = 1'b1;
        check("halted.strobes", {8'd0, sig_now()}, {8'd0, S_HALTD});
      end else begin
        drain_cycles++;
        check($sformatf("drain%0d.strobes", k), {8'd0, sig_now()},
              {8'd0, (k == 1) ? S_FRZ : S_DRAIN});
      end
      @(posedge clk);
      #1;
    end
    check("drain.halt_reached", {15'd0, done}, 16'd1);
    check("drain.cycles", 16'(drain_cycles), 16'd4);

    apply("halted_hold", mk(1, 0, 0, 0, 0, 0, 0, 0, S_HALTD, 3, 2));
    apply("halted_busy", mk(1, 4, 0, 0, 1, 4, 0, 1, S_HALTD, 3, 2));
    apply("halted_rst",  mk(0, 0, 0, 0, 0, 0, 0, 0, S_RST,   3, 2));
    apply("post_rst",    mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV,   0, 0));

    // 17 load-use stalls: 16-bit counter reaches 17, 4-bit counter sticks at 15.
    for (int i = 0; i < 17; i++) begin
      apply($sformatf("sat_lu%0d", i),  mk(1, 12, 0, 0, 1, 12, 0, 0, S_LU, i, 0));
      apply($sformatf("sat_adv%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 0, S_ADV, i + 1, 0));
    end
    @(negedge clk);
    check("sat.stall_cnt", {12'd0, s_stall_cnt}, 16'd15);
    check("sat.flush_cnt", {12'd0, s_flush_cnt}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
